// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus transaction per aligned access, stalls the pipeline
// until the data phase completes, and formats store and load data by access size.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_ls_ena_i,
    input  logic [3:0]  ex_ls_sel_i,
    input  logic [31:0] ex_alu_res_i,
    input  logic        ex_wb_reg_sel_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_wb_data_o,
    output logic        mem_stall_o,
    output logic        mem_adel_o,
    output logic        mem_ades_o,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_reg, state_next;
    logic        cancel_reg, cancel_next;
    logic [31:0] rdata_reg;
    logic        unsigned_reg;
    logic [1:0]  size_eff;
    logic        misaligned;
    logic        start;
    logic [31:0] wdata_rep;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_data;

    assign size_eff   = (ex_ls_sel_i[1:0] == 2'b11) ? 2'b10 : ex_ls_sel_i[1:0];
    assign misaligned = ((size_eff == 2'b01) && ex_alu_res_i[0]) ||
                        ((size_eff == 2'b10) && (ex_alu_res_i[1:0] != 2'b00));
    assign start      = rst && (state_reg == IDLE) && ex_ls_ena_i && !misaligned && !flush;

    always_comb begin
        case (size_eff)
            2'b00:   wdata_rep = {4{mem_wdata_i[7:0]}};
            2'b01:   wdata_rep = {2{mem_wdata_i[15:0]}};
            default: wdata_rep = mem_wdata_i;
        endcase
    end

    // Bus fields are latched when the request starts so they stay stable while waiting for addr_ok
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cancel_reg   <= 1'b0;
            rdata_reg    <= 32'd0;
            unsigned_reg <= 1'b0;
            data_addr    <= 32'd0;
            data_wdata   <= 32'd0;
            data_size    <= 2'd0;
            data_wr      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cancel_reg <= cancel_next;
            if (start) begin
                data_addr    <= ex_alu_res_i;
                data_wdata   <= wdata_rep;
                data_size    <= size_eff;
                data_wr      <= ex_ls_sel_i[3];
                unsigned_reg <= ex_ls_sel_i[2];
            end
            if ((state_reg == DATA) && data_data_ok && !cancel_reg && !flush)
                rdata_reg <= data_rdata;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cancel_next = cancel_reg;
        mem_stall_o = 1'b0;
        mem_adel_o  = 1'b0;
        mem_ades_o  = 1'b0;
        case (state_reg)
            IDLE: begin
                cancel_next = 1'b0;
                if (ex_ls_ena_i && misaligned) begin
                    mem_adel_o = !ex_ls_sel_i[3];
                    mem_ades_o = ex_ls_sel_i[3];
                end
                if (start) begin
                    mem_stall_o = 1'b1;
                    state_next  = ADDR;
                end
            end
            ADDR: begin
                mem_stall_o = 1'b1;
                if (flush)
                    cancel_next = 1'b1;
                if (data_addr_ok)
                    state_next = DATA;
            end
            DATA: begin
                mem_stall_o = 1'b1;
                if (flush)
                    cancel_next = 1'b1;
                if (data_data_ok) begin
                    // A squashed access still drains the bus but never presents a result
                    if (cancel_reg || flush) begin
                        state_next  = IDLE;
                        cancel_next = 1'b0;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!rst) begin
            mem_stall_o = 1'b0;
            mem_adel_o  = 1'b0;
            mem_ades_o  = 1'b0;
        end
    end

    assign data_req = (state_reg == ADDR);

    always_comb begin
        byte_val = rdata_reg[{data_addr[1:0], 3'b000} +: 8];
        half_val = data_addr[1] ? rdata_reg[31:16] : rdata_reg[15:0];
        case (data_size)
            2'b00:   load_data = unsigned_reg ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   load_data = unsigned_reg ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_data = rdata_reg;
        endcase
    end

    assign mem_wb_data_o = (ex_wb_reg_sel_i && (state_reg == DONE)) ? load_data : ex_alu_res_i;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: one task per scenario, each comparing outputs against
// hand-computed values one time unit after the rising edge.
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_ls_ena_i;
    logic [3:0]  ex_ls_sel_i;
    logic [31:0] ex_alu_res_i;
    logic        ex_wb_reg_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_wb_data_o;
    logic        mem_stall_o;
    logic        mem_adel_o;
    logic        mem_ades_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int pass_cnt = 0;
    int total_cnt = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_ls_ena_i(ex_ls_ena_i), .ex_ls_sel_i(ex_ls_sel_i), .ex_alu_res_i(ex_alu_res_i),
        .ex_wb_reg_sel_i(ex_wb_reg_sel_i), .mem_wdata_i(mem_wdata_i),
        .mem_wb_data_o(mem_wb_data_o), .mem_stall_o(mem_stall_o),
        .mem_adel_o(mem_adel_o), .mem_ades_o(mem_ades_o),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts stall cycles of the current access; leaves time in the first non-stalled cycle
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        while (mem_stall_o && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; ex_ls_ena_i = 1'b0; ex_ls_sel_i = 4'd0;
        ex_alu_res_i = 32'hCAFE_0000; ex_wb_reg_sel_i = 1'b1; mem_wdata_i = 32'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        #3;
        total_cnt++; if (data_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", data_req); else pass_cnt++;
        total_cnt++; if (mem_stall_o !== 1'b0) $display("FAIL reset_stall: got %0b want 0", mem_stall_o); else pass_cnt++;
        total_cnt++; if (data_addr !== 32'd0) $display("FAIL reset_addr: got %h want 0", data_addr); else pass_cnt++;
        total_cnt++; if (data_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", data_wdata); else pass_cnt++;
        total_cnt++; if ({data_size, data_wr} !== 3'd0) $display("FAIL reset_size_wr: got %b want 000", {data_size, data_wr}); else pass_cnt++;
        total_cnt++; if (mem_wb_data_o !== 32'hCAFE_0000) $display("FAIL reset_wb: got %h want cafe0000", mem_wb_data_o); else pass_cnt++;
        tick();
        rst = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_lb();
        ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0000; ex_alu_res_i = 32'h0000_1003; ex_wb_reg_sel_i = 1'b1;
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF_FF00;
        #1;
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b10) $display("FAIL lb_idle: stall,req got %b want 10", {mem_stall_o, data_req}); else pass_cnt++;
        tick();
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b11) $display("FAIL lb_addr: stall,req got %b want 11", {mem_stall_o, data_req}); else pass_cnt++;
        total_cnt++; if (data_addr !== 32'h1003 || data_size !== 2'd0 || data_wr !== 1'b0) $display("FAIL lb_bus: addr %h size %0d wr %0b want 1003 0 0", data_addr, data_size, data_wr); else pass_cnt++;
        tick();
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b10) $display("FAIL lb_data: stall,req got %b want 10", {mem_stall_o, data_req}); else pass_cnt++;
        tick();
        total_cnt++; if (mem_stall_o !== 1'b0) $display("FAIL lb_done_stall: got %0b want 0", mem_stall_o); else pass_cnt++;
        total_cnt++; if (mem_wb_data_o !== 32'hFFFF_FF80) $display("FAIL lb_wb: got %h want ffffff80", mem_wb_data_o); else pass_cnt++;
        ex_ls_ena_i = 1'b0;
        tick();
        total_cnt++; if (mem_wb_data_o !== 32'h1003) $display("FAIL lb_after: got %h want 00001003", mem_wb_data_o); else pass_cnt++;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        $display("test_lb done");
    endtask

    task automatic test_sh();
        ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b1001; ex_alu_res_i = 32'h0000_2002; ex_wb_reg_sel_i = 1'b0;
        mem_wdata_i = 32'h1234_ABCD;
        #1;
        tick();
        total_cnt++; if (data_req !== 1'b1) $display("FAIL sh_req: got %0b want 1", data_req); else pass_cnt++;
        total_cnt++; if (data_wdata !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want abcdabcd", data_wdata); else pass_cnt++;
        total_cnt++; if (data_size !== 2'd1 || data_wr !== 1'b1 || data_addr !== 32'h2002) $display("FAIL sh_bus: size %0d wr %0b addr %h want 1 1 2002", data_size, data_wr, data_addr); else pass_cnt++;
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        tick();
        tick();
        total_cnt++; if (mem_stall_o !== 1'b0 || mem_wb_data_o !== 32'h2002) $display("FAIL sh_done: stall %0b wb %h want 0 00002002", mem_stall_o, mem_wb_data_o); else pass_cnt++;
        ex_ls_ena_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick();
        $display("test_sh done");
    endtask

    task automatic test_misaligned();
        ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_alu_res_i = 32'h0000_1001;
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        #1;
        total_cnt++; if ({mem_adel_o, mem_ades_o} !== 2'b10) $display("FAIL lw_mis_exc: adel,ades got %b want 10", {mem_adel_o, mem_ades_o}); else pass_cnt++;
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b00) $display("FAIL lw_mis_idle: stall,req got %b want 00", {mem_stall_o, data_req}); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++; if ({mem_stall_o, data_req} !== 2'b00) $display("FAIL lw_mis_hold%0d: stall,req got %b want 00", i, {mem_stall_o, data_req}); else pass_cnt++;
        end
        ex_ls_sel_i = 4'b1001; ex_alu_res_i = 32'h0000_3001;
        #1;
        total_cnt++; if ({mem_adel_o, mem_ades_o, mem_stall_o} !== 3'b010) $display("FAIL sh_mis: adel,ades,stall got %b want 010", {mem_adel_o, mem_ades_o, mem_stall_o}); else pass_cnt++;
        ex_ls_ena_i = 1'b0;
        #1;
        total_cnt++; if ({mem_adel_o, mem_ades_o} !== 2'b00) $display("FAIL mis_noena: adel,ades got %b want 00", {mem_adel_o, mem_ades_o}); else pass_cnt++;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick();
        $display("test_misaligned done");
    endtask

    task automatic test_delay();
        ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_alu_res_i = 32'h0000_4000; ex_wb_reg_sel_i = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        #1;
        tick();
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if ({mem_stall_o, data_req} !== 2'b11 || data_addr !== 32'h4000) $display("FAIL delay_addr%0d: stall,req %b addr %h want 11 4000", i, {mem_stall_o, data_req}, data_addr); else pass_cnt++;
            tick();
        end
        data_addr_ok = 1'b1;
        #1;
        total_cnt++; if (data_req !== 1'b1) $display("FAIL delay_ack_req: got %0b want 1", data_req); else pass_cnt++;
        tick();
        data_addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++; if ({mem_stall_o, data_req} !== 2'b10) $display("FAIL delay_data%0d: stall,req %b want 10", i, {mem_stall_o, data_req}); else pass_cnt++;
            tick();
        end
        data_data_ok = 1'b1;
        tick();
        total_cnt++; if (mem_stall_o !== 1'b0 || mem_wb_data_o !== 32'hDEAD_BEEF) $display("FAIL delay_done: stall %0b wb %h want 0 deadbeef", mem_stall_o, mem_wb_data_o); else pass_cnt++;
        ex_ls_ena_i = 1'b0; data_data_ok = 1'b0;
        tick();
        $display("test_delay done");
    endtask

    task automatic test_load_ext();
        logic [3:0]  sel_t   [4] = '{4'b0101, 4'b0001, 4'b0100, 4'b0000};
        logic [31:0] addr_t  [4] = '{32'h1002, 32'h1000, 32'h1001, 32'h1000};
        logic [31:0] rdata_t [4] = '{32'h8001_1234, 32'h0000_F00F, 32'h0000_9A00, 32'h0000_007F};
        logic [31:0] exp_t   [4] = '{32'h0000_8001, 32'hFFFF_F00F, 32'h0000_009A, 32'h0000_007F};
        int n;
        for (int i = 0; i < 4; i++) begin
            ex_ls_ena_i = 1'b1; ex_ls_sel_i = sel_t[i]; ex_alu_res_i = addr_t[i]; ex_wb_reg_sel_i = 1'b1;
            data_rdata = rdata_t[i]; data_addr_ok = 1'b1; data_data_ok = 1'b1;
            count_stalls(n);
            total_cnt++; if (n != 3) $display("FAIL ext%0d_stalls: got %0d want 3", i, n); else pass_cnt++;
            total_cnt++; if (mem_wb_data_o !== exp_t[i]) $display("FAIL ext%0d_wb: got %h want %h", i, mem_wb_data_o, exp_t[i]); else pass_cnt++;
            ex_ls_ena_i = 1'b0;
            tick();
        end
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        $display("test_load_ext done");
    endtask

    task automatic test_flush();
        int n;
        ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b0010; ex_alu_res_i = 32'h0000_5000; ex_wb_reg_sel_i = 1'b1;
        data_rdata = 32'h1111_1111; data_addr_ok = 1'b1; data_data_ok = 1'b0;
        #1;
        tick();
        tick();
        flush = 1'b1;
        #1;
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b10) $display("FAIL flush_data: stall,req %b want 10", {mem_stall_o, data_req}); else pass_cnt++;
        tick();
        flush = 1'b0; ex_ls_ena_i = 1'b0; data_data_ok = 1'b1;
        #1;
        total_cnt++; if (mem_stall_o !== 1'b1) $display("FAIL flush_wait: stall %0b want 1", mem_stall_o); else pass_cnt++;
        tick();
        data_data_ok = 1'b0;
        #1;
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b00 || mem_wb_data_o !== 32'h5000) $display("FAIL flush_nodone: stall,req %b wb %h want 00 00005000", {mem_stall_o, data_req}, mem_wb_data_o); else pass_cnt++;
        tick();
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b00) $display("FAIL flush_idle: stall,req %b want 00", {mem_stall_o, data_req}); else pass_cnt++;
        ex_ls_ena_i = 1'b1; ex_alu_res_i = 32'h0000_6000; data_rdata = 32'h2222_2222;
        data_addr_ok = 1'b1; data_data_ok = 1'b1;
        count_stalls(n);
        total_cnt++; if (n != 3 || mem_wb_data_o !== 32'h2222_2222) $display("FAIL flush_next: stalls %0d wb %h want 3 22222222", n, mem_wb_data_o); else pass_cnt++;
        ex_ls_ena_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick();
        $display("test_flush done");
    endtask

    task automatic test_reset_mid();
        ex_ls_ena_i = 1'b1; ex_ls_sel_i = 4'b1010; ex_alu_res_i = 32'h0000_7000; mem_wdata_i = 32'h5555_AAAA;
        #1;
        tick();
        total_cnt++; if (data_req !== 1'b1) $display("FAIL rmid_pre: req %0b want 1", data_req); else pass_cnt++;
        #2;
        rst = 1'b0;
        #1;
        total_cnt++; if ({mem_stall_o, data_req, data_wr, data_size} !== 5'd0) $display("FAIL rmid_ctl: stall,req,wr,size %b want 00000", {mem_stall_o, data_req, data_wr, data_size}); else pass_cnt++;
        total_cnt++; if (data_addr !== 32'd0 || data_wdata !== 32'd0) $display("FAIL rmid_bus: addr %h wdata %h want 0 0", data_addr, data_wdata); else pass_cnt++;
        ex_ls_ena_i = 1'b0;
        tick();
        rst = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h3333_3333; ex_wb_reg_sel_i = 1'b1;
        #1;
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b00) $display("FAIL rmid_rel: stall,req %b want 00", {mem_stall_o, data_req}); else pass_cnt++;
        tick();
        total_cnt++; if ({mem_stall_o, data_req} !== 2'b00 || mem_wb_data_o !== 32'h7000) $display("FAIL rmid_stray: stall,req %b wb %h want 00 00007000", {mem_stall_o, data_req}, mem_wb_data_o); else pass_cnt++;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        tick();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_delay();
        test_load_ext();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
